// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle for mem_access_unit.
// master: the requesting CPU/controller side; slave: the memory access unit.
interface mem_access_if;
  logic [3:0]  mem_mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        align_err;

  modport master (output mem_mode, addr, wdata,
                  input  rdata, stall, done, align_err);
  modport slave  (input  mem_mode, addr, wdata,
                  output rdata, stall, done, align_err);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one timed access (SETUP, WAIT_CYCLES x ACCESS, DONE)
// on an external 32-bit asynchronous SRAM with byte-lane enables.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned LW/SW go straight to DONE
// with align_err raised and no SRAM strobes; when undefined align_err is 0.
// Access codes: IO_NOP=0, IO_LW=1, IO_LB=2, IO_SW=3, IO_SB=4; others act as NOP.
module mem_access_unit #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_if.slave       cpu,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LW  = 4'd1;
  localparam logic [3:0] IO_LB  = 4'd2;
  localparam logic [3:0] IO_SW  = 4'd3;
  localparam logic [3:0] IO_SB  = 4'd4;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        mode_q, mode_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              align_q, align_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [31:0]       dq_o_q, dq_o_d;

  logic       req_s;
  logic       misalign_s;
  logic [3:0] cur_mode_s;
  logic [1:0] cur_lane_s;
  logic       store_s;
  logic       strobe_state_s;
  logic       unused_addr_s;

  function automatic logic is_req(input logic [3:0] mode);
    return (mode == IO_LW) || (mode == IO_LB) || (mode == IO_SW) || (mode == IO_SB);
  endfunction

  function automatic logic is_store(input logic [3:0] mode);
    return (mode == IO_SW) || (mode == IO_SB);
  endfunction

  function automatic logic [31:0] sext_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    b = word[8*lane +: 8];
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [3:0] lane_be_n(input logic [3:0] mode, input logic [1:0] lane);
    if (mode == IO_SB) begin
      return ~(4'b0001 << lane);
    end else begin
      return 4'b0000;
    end
  endfunction

  assign req_s         = is_req(cpu.mem_mode) && (cpu.mem_mode != IO_NOP);
  assign unused_addr_s = ^cpu.addr[31:ADDR_W+2];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = ((cpu.mem_mode == IO_LW) || (cpu.mem_mode == IO_SW)) &&
                      (cpu.addr[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // In IDLE the live request drives the first-cycle outputs; afterwards the latched copy does.
  assign cur_mode_s = (state_q == S_IDLE) ? cpu.mem_mode : mode_q;
  assign cur_lane_s = (state_q == S_IDLE) ? cpu.addr[1:0] : lane_q;
  assign store_s    = is_store(cur_mode_s);

  // Next-state, latching and registered-output computation for the access sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    saddr_d = saddr_q;
    dq_o_d  = dq_o_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          mode_d = cpu.mem_mode;
          lane_d = cpu.addr[1:0];
          if (misalign_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            saddr_d = cpu.addr[ADDR_W+1:2];
            dq_o_d  = (cpu.mem_mode == IO_SB) ? {4{cpu.wdata[7:0]}} : cpu.wdata;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = WAIT_INIT;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          // Final strobe cycle: capture pad data for loads only.
          if (mode_q == IO_LB) begin
            rdata_d = sext_byte(sram_dq_i, lane_q);
          end else if (mode_q == IO_LW) begin
            rdata_d = sram_dq_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    strobe_state_s = (state_d == S_SETUP) || (state_d == S_ACCESS);
    done_d  = (state_d == S_DONE);
`ifdef MEM_ALIGN_CHECK_EN
    align_d = (state_q == S_IDLE) && (state_d == S_DONE);
`else
    align_d = 1'b0;
`endif
    ce_n_d  = !strobe_state_s;
    oe_n_d  = !(strobe_state_s && !store_s);
    we_n_d  = !((state_d == S_ACCESS) && store_s);
    be_n_d  = strobe_state_s ? lane_be_n(cur_mode_s, cur_lane_s) : 4'hF;
    // Store data stays driven one extra cycle (DONE) for hold time, but not on the skip path.
    dq_oe_d = store_s && (strobe_state_s || ((state_d == S_DONE) && (state_q == S_ACCESS)));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      mode_q  <= IO_NOP;
      lane_q  <= 2'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      align_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'hF;
      dq_oe_q <= 1'b0;
      saddr_q <= '0;
      dq_o_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      align_q <= align_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      dq_oe_q <= dq_oe_d;
      saddr_q <= saddr_d;
      dq_o_q  <= dq_o_d;
    end
  end

  assign cpu.rdata     = rdata_q;
  assign cpu.done      = done_q;
  assign cpu.align_err = align_q;
  assign cpu.stall     = req_s & ~done_q;
  assign sram_addr     = saddr_q;
  assign sram_dq_o     = dq_o_q;
  assign sram_dq_oe    = dq_oe_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_be_n     = be_n_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues requests and pushes the
// expected response computed from a word-array memory model; a monitor pops and
// compares on every done pulse and checks the SRAM pin protocol each cycle.
module tb_mem_access_unit;
  localparam int W  = 2;
  localparam int AW = 20;
  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LW  = 4'd1;
  localparam logic [3:0] IO_LB  = 4'd2;
  localparam logic [3:0] IO_SW  = 4'd3;
  localparam logic [3:0] IO_SB  = 4'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_if bus();
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  mem_access_unit #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cpu(bus),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SRAM pad model (16 words, aliased) ----------------
  logic [31:0] init_val [16];
  logic [31:0] sram_mem [16];
  logic        init_en;
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[3:0]] : 32'hA5A5_5A5A;

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 16; i++) sram_mem[i] <= init_val[i];
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int l = 0; l < 4; l++)
        if (!sram_be_n[l]) sram_mem[sram_addr[3:0]][8*l +: 8] <= sram_dq_o[8*l +: 8];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        aerr;
    int          lat;
    int          we_cnt;
    int          oe_cnt;
    logic [AW-1:0] waddr;
    logic [3:0]  be_n;
    logic [31:0] dq;
    logic        store;
    int          issue;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] ref_rdata;
  logic        abort_mode;

  // Issue one access at the current (post-edge) time and wait for its done pulse.
  task automatic issue(input logic [3:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit scramble);
    exp_t e;
    logic [1:0] lane;
    logic [3:0] w;
    logic [7:0] b;
    bit misal, store, got;
    lane  = addr[1:0];
    w     = addr[5:2];
    store = (mode == IO_SW) || (mode == IO_SB);
`ifdef MEM_ALIGN_CHECK_EN
    misal = ((mode == IO_LW) || (mode == IO_SW)) && (lane != 2'b00);
`else
    misal = 1'b0;
`endif
    if (!misal) begin
      case (mode)
        IO_LW: ref_rdata = ref_mem[w];
        IO_LB: begin b = ref_mem[w] >> (8 * lane); ref_rdata = {{24{b[7]}}, b}; end
        IO_SW: ref_mem[w] = wdata;
        IO_SB: ref_mem[w][8*lane +: 8] = wdata[7:0];
        default: ;
      endcase
    end
    e.rdata  = ref_rdata;
    e.aerr   = misal;
    e.lat    = misal ? 1 : W + 2;
    e.we_cnt = (store && !misal) ? W : 0;
    e.oe_cnt = (!store && !misal) ? W + 1 : 0;
    e.waddr  = addr[AW+1:2];
    e.be_n   = (mode == IO_SB) ? ~(4'b0001 << lane) : 4'b0000;
    e.dq     = (mode == IO_SB) ? {4{wdata[7:0]}} : wdata;
    e.store  = store;
    e.issue  = cyc;
    sb_q.push_back(e);
    bus.mem_mode = mode;
    bus.addr     = addr;
    bus.wdata    = wdata;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        check("stall_in_done", {31'd0, bus.stall}, 32'd0);
      end else begin
        check("stall_pending", {31'd0, bus.stall}, 32'd1);
        if (scramble && k >= 1) begin
          bus.addr  = $urandom;
          bus.wdata = $urandom;
        end
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Hold a non-request code for n cycles (unknown codes must behave as NOP).
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus.mem_mode = ($urandom_range(0, 1) == 0) ? IO_NOP : 4'($urandom_range(5, 15));
      @(negedge clk);
      check("stall_idle", {31'd0, bus.stall}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- monitor ----------------
  int mon_we = 0;
  int mon_oe = 0;
  always @(negedge clk) begin
    exp_t h;
    if (rst) begin
      mon_we = 0;
      mon_oe = 0;
    end else begin
      check("we_oe_exclusive", {31'd0, sram_we_n | sram_oe_n}, 32'd1);
      if (!sram_oe_n) check("dq_oe_on_load", {31'd0, sram_dq_oe}, 32'd0);
      if (!sram_we_n) mon_we++;
      if (!sram_oe_n) mon_oe++;
      if (!bus.done) check("align_err_idle", {31'd0, bus.align_err}, 32'd0);
      if (!sram_ce_n && !abort_mode) begin
        if (sb_q.size() == 0) begin
          check("strobe_without_txn", 32'd1, 32'd0);
        end else begin
          h = sb_q[0];
          check("sram_addr", {12'd0, sram_addr}, {12'd0, h.waddr});
          check("sram_be_n", {28'd0, sram_be_n}, {28'd0, h.be_n});
          if (h.store) begin
            check("dq_oe_store", {31'd0, sram_dq_oe}, 32'd1);
            check("sram_dq_o", sram_dq_o, h.dq);
          end
        end
      end
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          h = sb_q.pop_front();
          check("rdata", bus.rdata, h.rdata);
          check("align_err", {31'd0, bus.align_err}, {31'd0, h.aerr});
          check("latency", 32'(cyc - h.issue), 32'(h.lat));
          check("we_low_cycles", 32'(mon_we), 32'(h.we_cnt));
          check("oe_low_cycles", 32'(mon_oe), 32'(h.oe_cnt));
          check("ce_n_in_done", {31'd0, sram_ce_n}, 32'd1);
          check("dq_oe_hold", {31'd0, sram_dq_oe}, {31'd0, h.store && !h.aerr});
        end
        mon_we = 0;
        mon_oe = 0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (tests %0d)", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    abort_mode   = 1'b0;
    ref_rdata    = 32'd0;
    bus.mem_mode = IO_NOP;
    bus.addr     = 32'd0;
    bus.wdata    = 32'd0;
    for (int i = 0; i < 16; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end
    init_en = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    init_en = 1'b0;
    @(negedge clk);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check("rst_oe_we_n", {30'd0, sram_oe_n, sram_we_n}, 32'd3);
    check("rst_be_n", {28'd0, sram_be_n}, 32'hF);
    check("rst_dq", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_addr_dq_o", sram_dq_o | {12'd0, sram_addr}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;

    // Directed accesses from the plan, back-to-back (no gap between them).
    issue(IO_SW, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    issue(IO_LW, 32'h0000_0010, 32'h0, 1'b0);
    issue(IO_SW, 32'h0000_0010, 32'h80FF_0000, 1'b0);
    issue(IO_LB, 32'h0000_0013, 32'h0, 1'b0);
    issue(IO_LB, 32'h0000_0012, 32'h0, 1'b0);
    issue(IO_SW, 32'h0000_0010, 32'h0000_7F00, 1'b0);
    issue(IO_LB, 32'h0000_0011, 32'h0, 1'b1);
    issue(IO_SB, 32'h0000_0006, 32'h1234_56AB, 1'b1);
    issue(IO_LW, 32'h0000_0004, 32'h0, 1'b0);
    issue(IO_LW, 32'h0000_0002, 32'h0, 1'b0);
    issue(IO_SW, 32'h0000_0003, 32'h5555_AAAA, 1'b0);
    issue(IO_LW, 32'h0000_0010, 32'h0, 1'b0);
    idle(2);

    // Abort an LW in its ACCESS phase with reset.
    abort_mode   = 1'b1;
    bus.mem_mode = IO_LW;
    bus.addr     = 32'h0000_0010;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_mode = IO_NOP;
    @(posedge clk); #1;
    check("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check("abort_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    ref_rdata = 32'd0;
    abort_mode = 1'b0;
    idle(6);

    // Randomized traffic with random gaps (gap 0 = back-to-back).
    for (int t = 0; t < 150; t++) begin
      logic [3:0] m;
      case ($urandom_range(0, 3))
        0: m = IO_LW;
        1: m = IO_LB;
        2: m = IO_SW;
        default: m = IO_SB;
      endcase
      issue(m, $urandom, $urandom, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    idle(4);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
